shift_normalizer: RTL
=====================

// Module: shift_normalizer
// PURPOSE
//  Multi-cycle inverse of the barrel shifter: given a word, finds the shift amount that normalizes it
//  (leading zeros, trailing zeros or redundant sign bits) and returns both count and normalized word.
//  Sits beside the ALU in EX as a valid/ready functional unit for CLZ/CTZ/CLS-type ops and FP-style normalization.
//  Binary search, one 16/8/4/2/1 stage per clock.
// PARAMETERS
//  WIDTH  32                  data width; only 32 supported (5 stages)
//  CW     $clog2(WIDTH)+1     count width (6)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, synchronous, active-high
//  flush      in   1      pipeline flush; aborts any operation
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept; equals (state==IDLE)
//  in_data    in   WIDTH  operand
//  in_mode    in   2      00 CLZ, 01 CTZ, 10 CLS, 11 reserved (behaves as CLZ)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_value  out  WIDTH  normalized word
//  out_count  out  CW     shift amount found
//  out_zero   out  1      operand had no significant bit (see below)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_value=0, out_count=0, out_zero=0; in_ready=1 from first post-reset cycle.
//  - FSM: IDLE -> RUN (stage idx 0..4) -> DONE -> IDLE.
//  - Accept edge (in_valid&&in_ready&&!flush): latch in_data into working reg w, mode, count=0, zero flag; go RUN.
//  - RUN, stage k in {16,8,4,2,1} (idx 0..4), one per edge:
//    CLZ: if w[31:32-k]==0 then w<<=k, count+=k.
//    CTZ: if w[k-1:0]==0 then w>>=k (logical), count+=k.
//    CLS: if w[31:31-k] all equal w[31] then w<<=k (zero fill), count+=k.
//  - After 5th stage edge: DONE, out_valid=1. Latency: out_valid high 5 edges after accept edge.
//  - Zero cases: CLZ/CTZ with in_data==0 -> out_count=32, out_value=0, out_zero=1.
//    CLS with in_data==0 or 0xFFFF_FFFF -> out_count=31, out_zero=1, out_value=in_data<<31.
//    Otherwise out_zero=0; out_count in 0..31.
//  - DONE holds out_value/out_count/out_zero stable while out_ready=0; in_ready=0.
//  - out_valid&&out_ready edge -> IDLE; out_valid=0 next cycle; no back-to-back accept (min 7 cycles/op).
//  - out_value/out_count/out_zero: registered; retain last result after handshake; don't-care unless out_valid.
//  - flush: any state -> IDLE on that edge, out_valid=0; flush beats accept (in_valid ignored that edge).
//  - rst beats flush and all else; rst mid-RUN or in DONE drops result, no out_valid.
//  - in_data/in_mode sampled only on accept edge; changes during RUN/DONE have no effect.
//  - Counts never exceed 32; count adder is CW bits, no overflow possible (max 16+8+4+2+1=31, zero case forced 32).
// STRUCTURE
//  - Shared package riscv_shift_pkg: mode codes MODE_CLZ/MODE_CTZ/MODE_CLS and shifter op codes
//    (SLL/SRL/SRA), STAGE_AMT table {16,8,4,2,1}, state enum IDLE/RUN/DONE.
//  - One sub-module norm_stage: combinational single step (w, mode, k) -> (w_next, take); instanced once,
//    k selected by stage idx. FSM, counters and handshake live in shift_normalizer.
// TESTING
//  - CLZ 0x0000_0F00 -> out_count=20, out_value=0xF000_0000, out_zero=0, out_valid exactly 5 edges after accept.
//  - CTZ 0x0000_0F00 -> out_count=8, out_value=0x0000_000F; CLS 0xFFFF_F000 -> out_count=19, out_value=0x8000_0000.
//  - Zero/all-ones: CLZ 0 -> 32,0,zero=1; CTZ 0 -> 32,0,zero=1; CLS 0xFFFF_FFFF -> 31,0x8000_0000,zero=1; CLS 0x4000_0000 -> 0.
//  - Backpressure: out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; then handshake -> in_ready=1.
//  - flush at stage idx 2 (with in_valid=1 same edge) -> no out_valid, IDLE next cycle, in_ready=1; repeat with rst -> all outputs 0.
//  - Random 10k operands/modes vs reference model (count and value), with random out_ready stalls and sporadic flush.

Source files
------------

// File: rtl/riscv_shift_pkg.sv
// Shared definitions for the shift/normalize functional units:
// operation modes, shifter op codes, the binary-search stage table
// and the normalizer FSM state encoding.
package riscv_shift_pkg;

    localparam int unsigned NORM_WIDTH  = 32;
    localparam int unsigned NUM_STAGES  = 5;
    localparam int unsigned AMT_W       = 5;
    localparam int unsigned IDX_W       = 3;

    // Normalization mode; the reserved code is treated as CLZ.
    typedef enum logic [1:0] {
        MODE_CLZ = 2'b00,
        MODE_CTZ = 2'b01,
        MODE_CLS = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    // Shifter operation codes shared with the barrel shifter.
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_op_t;

    // Normalizer control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Binary-search step sizes, largest first.
    localparam logic [AMT_W-1:0] STAGE_AMT [NUM_STAGES] = '{
        5'd16, 5'd8, 5'd4, 5'd2, 5'd1
    };

    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

    // Step size for a stage index; out-of-range indices give a zero step.
    function automatic logic [AMT_W-1:0] stage_amt(input logic [IDX_W-1:0] idx);
        logic [AMT_W-1:0] amt;
        case (idx)
            3'd0:    amt = STAGE_AMT[0];
            3'd1:    amt = STAGE_AMT[1];
            3'd2:    amt = STAGE_AMT[2];
            3'd3:    amt = STAGE_AMT[3];
            3'd4:    amt = STAGE_AMT[4];
            default: amt = '0;
        endcase
        return amt;
    endfunction

    // Direction the working word moves when a stage takes its step.
    function automatic shift_op_t mode_shift_op(input mode_t mode);
        shift_op_t op;
        case (mode)
            MODE_CTZ: op = SHIFT_SRL;
            default:  op = SHIFT_SLL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/shift_normalizer_norm_stage.sv
// One binary-search step of the normalizer: tests whether the working
// word can be shifted by amt without losing a significant bit and, if so,
// produces the shifted word.
module norm_stage
    import riscv_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] w,
    input  mode_t            mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] w_next,
    output logic             take
);

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] sign_diff;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    shift_op_t        op;

    // Window masks, candidate shifts and the take decision for this step.
    always_comb begin
        ones      = '1;
        hi_mask   = ~(ones >> amt);
        lo_mask   = ~(ones << amt);
        // Bits that differ from the sign; CLS must see amt of them below bit 31 equal to it.
        sign_diff = w ^ {WIDTH{w[WIDTH-1]}};
        shl       = w << amt;
        shr       = w >> amt;
        op        = mode_shift_op(mode);
        take      = 1'b0;
        case (mode)
            MODE_CTZ: take = ((w & lo_mask) == '0);
            MODE_CLS: take = (((sign_diff << 1) & hi_mask) == '0);
            default:  take = ((w & hi_mask) == '0);
        endcase
        w_next = w;
        if (take) begin
            w_next = (op == SHIFT_SRL) ? shr : shl;
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer (CLZ / CTZ / CLS) with valid/ready handshakes.
// Binary search over step sizes 16/8/4/2/1, one step per clock, using a
// single shared norm_stage whose step size is selected by the stage index.
module shift_normalizer
    import riscv_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [CW-1:0]    out_count,
    output logic             out_zero
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] w;
    mode_t            mode;
    logic [CW-1:0]    cnt;
    logic             zero;

    logic             accept;
    logic             running;
    logic             last_stage;
    logic             in_zero;
    logic             in_ones;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] w_next;
    logic             take;
    logic [CW-1:0]    cnt_next;

    norm_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .w      (w),
        .mode   (mode),
        .amt    (amt),
        .w_next (w_next),
        .take   (take)
    );

    // Handshake qualifiers, step selection and the running count.
    always_comb begin
        accept     = in_valid && in_ready && !flush;
        running    = (state == RUN) && !flush;
        last_stage = (idx == LAST_STAGE);
        in_zero    = (in_data == '0);
        in_ones    = (in_data == '1);
        amt        = stage_amt(idx);
        cnt_next   = take ? (cnt + CW'(amt)) : cnt;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)              state_next = RUN;
            RUN:  if (last_stage)          state_next = DONE;
            DONE: if (out_ready)           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Working word, count and stage index; result registers load on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            w         <= '0;
            mode      <= MODE_CLZ;
            cnt       <= '0;
            zero      <= 1'b0;
            out_value <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
        end else if (accept) begin
            idx  <= '0;
            w    <= in_data;
            mode <= mode_t'(in_mode);
            cnt  <= '0;
            zero <= (in_mode == MODE_CLS) ? (in_zero || in_ones) : in_zero;
        end else if (running) begin
            idx <= idx + 3'd1;
            w   <= w_next;
            cnt <= cnt_next;
            if (last_stage) begin
                out_value <= w_next;
                out_zero  <= zero;
                // The search tops out at WIDTH-1; an all-zero CLZ/CTZ operand reports WIDTH.
                out_count <= (zero && (mode != MODE_CLS)) ? CW'(WIDTH) : cnt_next;
            end
        end
    end

endmodule
